// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: default bus widths and fetch FSM state encoding.
package cpu_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: PC control, instruction memory, decode handshake and branch redirect.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          Run;
  logic [AW-1:0] PcIn;
  logic          PcCountEn;
  logic          PcLoad;
  logic [AW-1:0] PcLoadAddr;
  logic [AW-1:0] MemAddr;
  logic          MemRd;
  logic [DW-1:0] MemData;
  logic [DW-1:0] Ir;
  logic [AW-1:0] IrPc;
  logic          IrValid;
  logic          IrReady;
  logic          BrTaken;
  logic [AW-1:0] BrTarget;

  modport master (
    input  Run, PcIn, MemData, IrReady, BrTaken, BrTarget,
    output PcCountEn, PcLoad, PcLoadAddr, MemAddr, MemRd, Ir, IrPc, IrValid
  );

  modport slave (
    output Run, PcIn, MemData, IrReady, BrTaken, BrTarget,
    input  PcCountEn, PcLoad, PcLoadAddr, MemAddr, MemRd, Ir, IrPc, IrValid
  );

endinterface

// File: rtl/fetch_latency_ctr.sv
// Memory latency down-counter; zero flags the decrement that brings the count to 0.
module fetch_latency_ctr #(
  parameter int MEM_LAT = 1
) (
  input  logic Clk,
  input  logic nReset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(MEM_LAT);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = dec && (count == CW'(1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: steps/redirects the PC, reads instruction memory into Ir, hands Ir to decode.
// state | meaning
// IDLE  | stopped, no outputs asserted
// ISSUE | memory read strobe and PC increment, one cycle
// WAIT  | counting down memory latency
// HOLD  | Ir valid, waiting for decode to accept
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MEM_LAT = 1
) (
  input logic          Clk,
  input logic          nReset,
  fetch_unit_if.master bus
);

  fetch_state_t  state, state_nxt;
  logic          lat_zero;
  logic          discard;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;

  fetch_latency_ctr #(.MEM_LAT(MEM_LAT)) u_lat (
    .Clk   (Clk),
    .nReset(nReset),
    .load  (state == ISSUE),
    .dec   (state == WAIT),
    .zero  (lat_zero)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.BrTaken) begin
      state_nxt = bus.Run ? ISSUE : IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.Run) state_nxt = ISSUE;
        ISSUE:   state_nxt = WAIT;
        WAIT:    if (lat_zero) state_nxt = HOLD;
        HOLD:    if (bus.IrReady) state_nxt = bus.Run ? ISSUE : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Redirect is combinational so the PC loads on the negedge before the edge that starts the refetch.
  always_comb begin
    bus.MemRd      = 1'b0;
    bus.PcCountEn  = 1'b0;
    bus.PcLoad     = 1'b0;
    bus.PcLoadAddr = '0;
    if (nReset) begin
      if (bus.BrTaken) begin
        bus.PcLoad     = 1'b1;
        bus.PcLoadAddr = bus.BrTarget;
      end else if (state == ISSUE) begin
        bus.MemRd     = 1'b1;
        bus.PcCountEn = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      mem_addr <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (state_nxt == ISSUE) begin
        mem_addr <= bus.PcIn;
      end
      if (bus.BrTaken) begin
        ir_valid <= 1'b0;
        if (state == WAIT) discard <= 1'b1;
      end else begin
        if (state == ISSUE) discard <= 1'b0;
        if (lat_zero && !discard) begin
          ir       <= bus.MemData;
          ir_pc    <= mem_addr;
          ir_valid <= 1'b1;
        end else if (ir_valid && bus.IrReady) begin
          ir_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.MemAddr = mem_addr;
  assign bus.Ir      = ir;
  assign bus.IrPc    = ir_pc;
  assign bus.IrValid = ir_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: MEM_LAT=1 and MEM_LAT=3 instances against an address/memory reference model.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_rd1 = 0, n_ce1 = 0, n_ce3 = 0, n_both = 0;
  logic [15:0] mem [256];
  logic [15:0] junk = 16'h0;
  logic [7:0]  pc1, pc3;
  logic [2:0]  rv1 = '0, rv3 = '0;
  logic [7:0]  ra1 [3];
  logic [7:0]  ra3 [3];

  int          w, k, nx, cyc, rd0, ce0;
  logic [7:0]  exp_addr, tgt;
  bit          br;

  fetch_unit_if #(.AW(8), .DW(16)) bus1 ();
  fetch_unit_if #(.AW(8), .DW(16)) bus3 ();

  fetch_unit #(.AW(8), .DW(16), .MEM_LAT(1)) dut1 (.Clk(Clk), .nReset(nReset), .bus(bus1));
  fetch_unit #(.AW(8), .DW(16), .MEM_LAT(3)) dut3 (.Clk(Clk), .nReset(nReset), .bus(bus3));

  always #5 Clk = ~Clk;

  // external program counters, updating on negedge
  always @(negedge Clk or negedge nReset) begin
    if (!nReset) pc1 <= '0;
    else if (bus1.PcLoad) pc1 <= bus1.PcLoadAddr;
    else if (bus1.PcCountEn) pc1 <= pc1 + 8'd1;
  end
  always @(negedge Clk or negedge nReset) begin
    if (!nReset) pc3 <= '0;
    else if (bus3.PcLoad) pc3 <= bus3.PcLoadAddr;
    else if (bus3.PcCountEn) pc3 <= pc3 + 8'd1;
  end
  assign bus1.PcIn = pc1;
  assign bus3.PcIn = pc3;

  // instruction memories: data valid exactly MEM_LAT cycles after the read strobe, junk otherwise
  always @(posedge Clk) begin
    junk   <= 16'($urandom);
    rv1    <= {rv1[1:0], bus1.MemRd};
    ra1[0] <= bus1.MemAddr;
    ra1[1] <= ra1[0];
    ra1[2] <= ra1[1];
    rv3    <= {rv3[1:0], bus3.MemRd};
    ra3[0] <= bus3.MemAddr;
    ra3[1] <= ra3[0];
    ra3[2] <= ra3[1];
  end
  assign bus1.MemData = rv1[0] ? mem[ra1[0]] : junk;
  assign bus3.MemData = rv3[2] ? mem[ra3[2]] : junk;

  always @(negedge Clk) begin
    if (bus1.MemRd) n_rd1++;
    if (bus1.PcCountEn) n_ce1++;
    if (bus3.PcCountEn) n_ce3++;
    if (bus1.PcLoad && bus1.PcCountEn) n_both++;
    if (bus3.PcLoad && bus3.PcCountEn) n_both++;
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic xfer1(input string tag, input logic [15:0] ir, input logic [7:0] pc,
                       input bit stop, output int wt);
    wt = 0;
    while (!(bus1.IrValid && bus1.IrReady) && wt < 50) begin
      tick();
      wt++;
    end
    if (!(bus1.IrValid && bus1.IrReady)) begin
      timeout({tag, "_wait"});
    end else begin
      chk({tag, "_ir"}, 32'(bus1.Ir), 32'(ir));
      chk({tag, "_irpc"}, 32'(bus1.IrPc), 32'(pc));
      if (stop) bus1.Run = 1'b0;
      tick();
      wt++;
    end
  endtask

  task automatic xfer3(input string tag, input logic [15:0] ir, input logic [7:0] pc,
                       input bit stop, output int wt);
    wt = 0;
    while (!(bus3.IrValid && bus3.IrReady) && wt < 50) begin
      tick();
      wt++;
    end
    if (!(bus3.IrValid && bus3.IrReady)) begin
      timeout({tag, "_wait"});
    end else begin
      chk({tag, "_ir"}, 32'(bus3.Ir), 32'(ir));
      chk({tag, "_irpc"}, 32'(bus3.IrPc), 32'(pc));
      if (stop) bus3.Run = 1'b0;
      tick();
      wt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'hA001;
    mem[8'h11] = 16'hA002;
    mem[8'h12] = 16'hA003;
    mem[8'h40] = 16'h4040;
    mem[8'hFF] = 16'hC0FF;
    mem[8'h00] = 16'hC000;
    mem[8'h30] = 16'h3030;
    mem[8'h31] = 16'h3131;
    mem[8'h50] = 16'h5050;
    mem[8'h51] = 16'h5151;
    bus1.Run = 1'b0; bus1.IrReady = 1'b0; bus1.BrTaken = 1'b0; bus1.BrTarget = '0;
    bus3.Run = 1'b0; bus3.IrReady = 1'b0; bus3.BrTaken = 1'b0; bus3.BrTarget = '0;

    // power-on reset
    tick();
    tick();
    chk("por_irvalid", 32'(bus1.IrValid), 0);
    chk("por_memrd", 32'(bus1.MemRd), 0);
    chk("por_memaddr", 32'(bus1.MemAddr), 0);
    chk("por_ir", 32'(bus1.Ir), 0);
    chk("por_irvalid3", 32'(bus3.IrValid), 0);
    nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_memrd", 32'(bus1.MemRd), 0);
    end

    // load PC=0x10 by redirect while idle
    bus1.BrTaken = 1'b1; bus1.BrTarget = 8'h10;
    #1;
    chk("ld_pcload", 32'(bus1.PcLoad), 1);
    chk("ld_addr", 32'(bus1.PcLoadAddr), 32'h10);
    chk("ld_noce", 32'(bus1.PcCountEn), 0);
    tick();
    bus1.BrTaken = 1'b0;

    // straight-line run
    rd0 = n_rd1; ce0 = n_ce1;
    bus1.Run = 1'b1; bus1.IrReady = 1'b1;
    xfer1("run0", 16'hA001, 8'h10, 1'b0, w);
    xfer1("run1", 16'hA002, 8'h11, 1'b0, w);
    chk("tput1", w, 3);
    xfer1("run2", 16'hA003, 8'h12, 1'b1, w);
    chk("tput2", w, 3);
    tick();
    tick();
    chk("run_countens", n_ce1 - ce0, 3);
    chk("run_memrds", n_rd1 - rd0, 3);

    // backpressure
    bus1.BrTaken = 1'b1; bus1.BrTarget = 8'h10;
    tick();
    bus1.BrTaken = 1'b0; bus1.IrReady = 1'b0; bus1.Run = 1'b1;
    k = 0;
    while (!bus1.IrValid && k < 20) begin
      tick();
      k++;
    end
    if (!bus1.IrValid) timeout("bp_valid");
    rd0 = n_rd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ir", 32'(bus1.Ir), 32'hA001);
      chk("bp_valid", 32'(bus1.IrValid), 1);
    end
    chk("bp_nord", n_rd1 - rd0, 0);
    bus1.IrReady = 1'b1;
    xfer1("bp_x", 16'hA001, 8'h10, 1'b0, w);
    chk("bp_issue", 32'(bus1.MemRd), 1);
    chk("bp_issue_addr", 32'(bus1.MemAddr), 32'h11);

    // redirect while the fetch of 0x11 is in flight
    tick();
    bus1.BrTaken = 1'b1; bus1.BrTarget = 8'h40;
    #1;
    chk("br_pcload", 32'(bus1.PcLoad), 1);
    chk("br_addr", 32'(bus1.PcLoadAddr), 32'h40);
    chk("br_noce", 32'(bus1.PcCountEn), 0);
    tick();
    bus1.BrTaken = 1'b0;
    chk("br_flush", 32'(bus1.IrValid), 0);
    xfer1("br_x", 16'h4040, 8'h40, 1'b1, w);

    // random traffic: backpressure and redirects against the address/memory model
    bus1.Run = 1'b1;
    exp_addr = 8'($urandom);
    bus1.BrTaken = 1'b1; bus1.BrTarget = exp_addr; bus1.IrReady = 1'b0;
    tick();
    nx = 0;
    cyc = 0;
    while (nx < 40 && cyc < 2000) begin
      br  = ($urandom_range(15) == 0);
      tgt = 8'($urandom);
      bus1.BrTaken  = br;
      bus1.BrTarget = tgt;
      bus1.IrReady  = !br && ($urandom_range(9) < 7);
      #1;
      if (br) begin
        chk("rnd_ldaddr", 32'(bus1.PcLoadAddr), 32'(tgt));
        exp_addr = tgt;
      end else if (bus1.IrValid && bus1.IrReady) begin
        chk("rnd_ir", 32'(bus1.Ir), 32'(mem[exp_addr]));
        chk("rnd_irpc", 32'(bus1.IrPc), 32'(exp_addr));
        exp_addr = exp_addr + 8'd1;
        nx++;
      end
      tick();
      cyc++;
    end
    if (nx < 40) timeout("rnd_progress");

    // address wrap
    bus1.Run = 1'b0; bus1.IrReady = 1'b1; bus1.BrTaken = 1'b1; bus1.BrTarget = 8'hFF;
    tick();
    bus1.BrTaken = 1'b0; bus1.Run = 1'b1;
    xfer1("wrap_ff", 16'hC0FF, 8'hFF, 1'b0, w);
    xfer1("wrap_00", 16'hC000, 8'h00, 1'b1, w);

    // reset in the middle of a fetch
    bus1.BrTaken = 1'b1; bus1.BrTarget = 8'h20; bus1.Run = 1'b1;
    tick();
    bus1.BrTaken = 1'b0; bus1.Run = 1'b0;
    tick();
    chk("rst_pre_addr", 32'(bus1.MemAddr), 32'h20);
    nReset = 1'b0;
    #1;
    chk("rst_ir", 32'(bus1.Ir), 0);
    chk("rst_irpc", 32'(bus1.IrPc), 0);
    chk("rst_irvalid", 32'(bus1.IrValid), 0);
    chk("rst_memaddr", 32'(bus1.MemAddr), 0);
    chk("rst_memrd", 32'(bus1.MemRd), 0);
    chk("rst_counten", 32'(bus1.PcCountEn), 0);
    tick();
    tick();
    nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_idle_memrd", 32'(bus1.MemRd), 0);
      chk("rst_idle_valid", 32'(bus1.IrValid), 0);
    end

    // MEM_LAT=3 instance
    bus3.BrTaken = 1'b1; bus3.BrTarget = 8'h30;
    tick();
    bus3.BrTaken = 1'b0; bus3.Run = 1'b1; bus3.IrReady = 1'b1;
    k = 0;
    while (!bus3.MemRd && k < 10) begin
      tick();
      k++;
    end
    if (!bus3.MemRd) timeout("lat3_memrd");
    k = 0;
    while (!bus3.IrValid && k < 10) begin
      tick();
      k++;
    end
    chk("lat3_gap", k, 4);
    chk("lat3_ir", 32'(bus3.Ir), 32'h3030);
    chk("lat3_irpc", 32'(bus3.IrPc), 32'h30);
    tick();
    chk("lat3_issue", 32'(bus3.MemRd), 1);
    bus3.BrTaken = 1'b1; bus3.BrTarget = 8'h50;
    #1;
    ce0 = n_ce3;
    chk("co_pcload", 32'(bus3.PcLoad), 1);
    chk("co_noce", 32'(bus3.PcCountEn), 0);
    tick();
    bus3.BrTaken = 1'b0;
    chk("co_noce_count", n_ce3 - ce0, 0);
    xfer3("co_x0", 16'h5050, 8'h50, 1'b0, w);
    xfer3("co_x1", 16'h5151, 8'h51, 1'b1, w);
    chk("lat3_tput", w, 5);

    chk("never_both", n_both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
